// File: rtl/hamming_rx.sv
// Serial Hamming(7,4) receiver: frames start/7 code bits/stop, corrects single-bit errors.
// Latency: dout/syn/corr/ccnt/dvalid update on the stop-bit edge; 9 enabled cycles per frame.
// Backpressure: none; en qualifies every sample, and en=0 freezes the receiver without strobes.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en, si          bit enable and serial line (idle high), sampled when en=1
//   dout, dvalid    corrected data {d3,d2,d1,d0} and its one-cycle strobe
//   syn, corr       syndrome of the last accepted frame, nonzero-syndrome flag
//   ferr            one-cycle strobe: stop bit was 0, frame discarded
//   busy            receiver is inside a frame
//   ccnt            saturating count of corrected frames
`timescale 1ns/1ps
module hamming_rx #(
  parameter int CNTW    = 8,
  parameter bit STOPCHK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            si,
  output logic [3:0]      dout,
  output logic            dvalid,
  output logic [2:0]      syn,
  output logic            corr,
  output logic            ferr,
  output logic            busy,
  output logic [CNTW-1:0] ccnt
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t     state;
  logic [2:0] idx;
  logic [6:0] sh;

  logic [2:0] s;
  logic [6:0] fix;
  logic [6:0] cw;
  logic       stop_ok;

  // Decode works on the fully assembled codeword while in STOP.
  always_comb begin
    s[0] = sh[0] ^ sh[2] ^ sh[4] ^ sh[6];
    s[1] = sh[1] ^ sh[2] ^ sh[5] ^ sh[6];
    s[2] = sh[3] ^ sh[4] ^ sh[5] ^ sh[6];
    fix  = 7'd0;
    if (s != 3'd0) begin
      // syndrome names the Hamming position, which is bit (syn-1) of the word
      fix = 7'b1 << (s - 3'd1);
    end
    cw      = sh ^ fix;
    stop_ok = si | ~STOPCHK;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 3'd0;
      sh     <= 7'd0;
      dout   <= 4'd0;
      dvalid <= 1'b0;
      syn    <= 3'd0;
      corr   <= 1'b0;
      ferr   <= 1'b0;
      ccnt   <= '0;
    end else begin
      // strobes last one clock regardless of en
      dvalid <= 1'b0;
      ferr   <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (!si) begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end
          DATA: begin
            sh[idx] <= si;
            idx     <= idx + 3'd1;
            if (idx == 3'd6) begin
              state <= STOP;
            end
          end
          STOP: begin
            if (stop_ok) begin
              dout   <= {cw[6], cw[5], cw[4], cw[2]};
              syn    <= s;
              corr   <= (s != 3'd0);
              dvalid <= 1'b1;
              if ((s != 3'd0) && !(&ccnt)) begin
                ccnt <= ccnt + CNTW'(1);
              end
            end else begin
              ferr <= 1'b1;
            end
            // a 0 in the stop slot is consumed here, never reused as a start bit
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hamming_rx.sv
`timescale 1ns/1ps
module tb_hamming_rx;

  logic clk = 1'b0;
  logic rst, en, si;

  logic [3:0] dout, dout2;
  logic       dvalid, dvalid2, corr, corr2, ferr, ferr2, busy, busy2;
  logic [2:0] syn, syn2;
  logic [7:0] ccnt;
  logic [1:0] ccnt2;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [3:0] exp_dout;
  logic [2:0] exp_syn;
  logic       exp_corr;
  int         exp_cnt, exp_cnt2;
  int         exp_nvalid, exp_nferr;

  // observed strobe activity
  int nvalid = 0, nferr = 0, nboth = 0;
  int encnt = 0, last_valid_en = 0, prev_valid_en = 0;

  hamming_rx #(.CNTW(8), .STOPCHK(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .si(si),
    .dout(dout), .dvalid(dvalid), .syn(syn), .corr(corr),
    .ferr(ferr), .busy(busy), .ccnt(ccnt)
  );

  hamming_rx #(.CNTW(2), .STOPCHK(1'b1)) dut2 (
    .clk(clk), .rst(rst), .en(en), .si(si),
    .dout(dout2), .dvalid(dvalid2), .syn(syn2), .corr(corr2),
    .ferr(ferr2), .busy(busy2), .ccnt(ccnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (en && !rst) encnt++;

  always @(negedge clk) begin
    if (dvalid) begin
      nvalid++;
      prev_valid_en = last_valid_en;
      last_valid_en = encnt;
    end
    if (ferr) nferr++;
    if (dvalid && ferr) nboth++;
  end

  // Non-strobe outputs may only move on enabled edges.
  always @(posedge clk) begin
    logic [16:0] snap;
    if (!en && !rst) begin
      snap = {dout, syn, corr, ccnt, busy};
      #1;
      checks++;
      if ({dout, syn, corr, ccnt, busy} !== snap) begin
        failures++;
        $display("FAIL hold_on_disabled_edge got=%h want=%h", {dout, syn, corr, ccnt, busy}, snap);
      end
    end
  end

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Present one bit and return once an enabled edge will sample it.
  task automatic drive_bit(input logic b, input bit rnd);
    int tries;
    tries = 0;
    do begin
      @(negedge clk);
      si = b;
      en = (rnd && tries < 32) ? 1'($urandom_range(0, 1)) : 1'b1;
      tries++;
    end while (!en);
  endtask

  // Sends a full frame (errpos 0 = clean, 1..7 = flipped Hamming position)
  // and returns #1 after the stop-bit edge. Updates the reference model.
  task automatic send_frame(input logic [3:0] d, input int errpos, input logic stopb, input bit rnd);
    logic [6:0] cw;
    cw = encode(d);
    if (errpos != 0) cw[errpos-1] = ~cw[errpos-1];
    drive_bit(1'b0, rnd);
    for (int i = 0; i < 7; i++) drive_bit(cw[i], rnd);
    drive_bit(stopb, rnd);
    @(posedge clk);
    #1;
    if (stopb) begin
      exp_dout = d;
      exp_syn  = 3'(errpos);
      exp_corr = (errpos != 0);
      if (errpos != 0 && exp_cnt < 255) exp_cnt++;
      if (errpos != 0 && exp_cnt2 < 3) exp_cnt2++;
      exp_nvalid++;
    end else begin
      exp_nferr++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      si = 1'b1;
      en = 1'b1;
    end
  endtask

  task automatic model_reset();
    exp_dout = 4'd0; exp_syn = 3'd0; exp_corr = 1'b0;
    exp_cnt = 0; exp_cnt2 = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; si = 1'b1;
    model_reset();
    exp_nvalid = 0; exp_nferr = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({dout, dvalid, syn, corr, ferr, busy} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {dout, dvalid, syn, corr, ferr, busy});
    end
    checks++;
    if (ccnt !== 8'd0 || ccnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_ccnt got=%0d/%0d want=0/0", ccnt, ccnt2);
    end
  endtask

  task automatic test_basic();
    send_frame(4'b1011, 0, 1'b1, 1'b0);
    checks++;
    if ({dvalid, dout, syn, corr, busy} !== {1'b1, 4'b1011, 3'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_clean got v=%b d=%b s=%0d c=%b busy=%b want v=1 d=1011 s=0 c=0 busy=0",
               dvalid, dout, syn, corr, busy);
    end
    checks++;
    if (ccnt !== 8'd0) begin
      failures++;
      $display("FAIL basic_clean_ccnt got=%0d want=0", ccnt);
    end
    @(negedge clk); si = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dvalid !== 1'b0) begin
      failures++;
      $display("FAIL dvalid_width got=%b want=0", dvalid);
    end
    send_frame(4'b1011, 5, 1'b1, 1'b0);
    checks++;
    if ({dvalid, dout, syn, corr} !== {1'b1, 4'b1011, 3'd5, 1'b1} || ccnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL basic_c4_flip got v=%b d=%b s=%0d c=%b cnt=%0d want v=1 d=1011 s=5 c=1 cnt=%0d",
               dvalid, dout, syn, corr, ccnt, exp_cnt);
    end
  endtask

  task automatic test_single_errors();
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 8; p++) begin
        send_frame(4'(d), p, 1'b1, 1'b0);
        checks++;
        if ({dvalid, dout, syn, corr} !== {1'b1, exp_dout, exp_syn, exp_corr}
            || ccnt !== 8'(exp_cnt) || ccnt2 !== 2'(exp_cnt2)) begin
          failures++;
          $display("FAIL single_error d=%0d pos=%0d got v=%b d=%b s=%0d c=%b cnt=%0d/%0d want d=%b s=%0d c=%b cnt=%0d/%0d",
                   d, p, dvalid, dout, syn, corr, ccnt, ccnt2, exp_dout, exp_syn, exp_corr, exp_cnt, exp_cnt2);
        end
      end
    end
  endtask

  task automatic test_framing();
    int nf0, nv0;
    nf0 = nferr; nv0 = nvalid;
    send_frame(4'($urandom_range(0, 15)), $urandom_range(0, 7), 1'b0, 1'b0);
    checks++;
    if ({ferr, dvalid, busy} !== 3'b100) begin
      failures++;
      $display("FAIL framing_strobe got ferr=%b dvalid=%b busy=%b want 1 0 0", ferr, dvalid, busy);
    end
    checks++;
    if ({dout, syn, corr} !== {exp_dout, exp_syn, exp_corr} || ccnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL framing_hold got d=%b s=%0d c=%b cnt=%0d want d=%b s=%0d c=%b cnt=%0d",
               dout, syn, corr, ccnt, exp_dout, exp_syn, exp_corr, exp_cnt);
    end
    send_frame(4'b0000, 0, 1'b1, 1'b0);
    checks++;
    if ({dvalid, dout, syn, corr} !== {1'b1, 4'b0000, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL framing_recover got v=%b d=%b s=%0d c=%b want v=1 d=0000 s=0 c=0",
               dvalid, dout, syn, corr);
    end
    idle_cycles(1);
    #1;
    checks++;
    if (nferr - nf0 !== 1) begin
      failures++;
      $display("FAIL framing_ferr_pulses got=%0d want=1", nferr - nf0);
    end
  endtask

  task automatic test_random_en();
    logic [3:0] d;
    int p;
    for (int k = 0; k < 20; k++) begin
      d = 4'($urandom_range(0, 15));
      p = $urandom_range(0, 7);
      send_frame(d, p, 1'b1, 1'b1);
      checks++;
      if ({dvalid, dout, syn, corr} !== {1'b1, d, 3'(p), p != 0} || ccnt !== 8'(exp_cnt)) begin
        failures++;
        $display("FAIL random_en k=%0d got v=%b d=%b s=%0d c=%b cnt=%0d want d=%b s=%0d cnt=%0d",
                 k, dvalid, dout, syn, corr, ccnt, d, p, exp_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    int p;
    for (int k = 0; k < 2; k++) begin
      d = 4'($urandom_range(0, 15));
      p = $urandom_range(1, 7);
      send_frame(d, p, 1'b1, 1'b0);
      checks++;
      if ({dvalid, dout, syn, corr} !== {1'b1, d, 3'(p), 1'b1}) begin
        failures++;
        $display("FAIL back_to_back k=%0d got v=%b d=%b s=%0d c=%b want d=%b s=%0d c=1",
                 k, dvalid, dout, syn, corr, d, p);
      end
    end
    idle_cycles(1);
    #1;
    checks++;
    if (last_valid_en - prev_valid_en !== 9) begin
      failures++;
      $display("FAIL back_to_back_spacing got=%0d want=9", last_valid_en - prev_valid_en);
    end
  endtask

  task automatic test_midframe_reset();
    int nv0, nf0, p;
    logic [6:0] cw;
    cw = encode(4'b0110);
    nv0 = nvalid; nf0 = nferr;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(cw[i], 1'b0);
    @(negedge clk);
    rst = 1'b1; si = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle_cycles(4);
    #1;
    checks++;
    if (nvalid !== nv0 || nferr !== nf0 || busy !== 1'b0 || ccnt !== 8'd0 || dout !== 4'd0) begin
      failures++;
      $display("FAIL midframe_reset got nv=%0d nf=%0d busy=%b cnt=%0d d=%b want nv=%0d nf=%0d busy=0 cnt=0 d=0000",
               nvalid, nferr, busy, ccnt, dout, nv0, nf0);
    end
    p = $urandom_range(1, 7);
    send_frame(4'b1001, p, 1'b1, 1'b0);
    checks++;
    if ({dvalid, dout, syn} !== {1'b1, 4'b1001, 3'(p)} || ccnt !== 8'd1) begin
      failures++;
      $display("FAIL after_reset_frame got v=%b d=%b s=%0d cnt=%0d want v=1 d=1001 s=%0d cnt=1",
               dvalid, dout, syn, ccnt, p);
    end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    rst = 1'b1; si = 1'b1; en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 1; k <= 5; k++) begin
      send_frame(4'($urandom_range(0, 15)), $urandom_range(1, 7), 1'b1, 1'b1);
      checks++;
      if (ccnt2 !== 2'((k < 3) ? k : 3) || ccnt !== 8'(k)) begin
        failures++;
        $display("FAIL saturation k=%0d got=%0d/%0d want=%0d/%0d",
                 k, ccnt2, ccnt, (k < 3) ? k : 3, k);
      end
    end
  endtask

  task automatic test_strobe_totals();
    idle_cycles(2);
    #1;
    checks++;
    if (nvalid !== exp_nvalid || nferr !== exp_nferr || nboth !== 0) begin
      failures++;
      $display("FAIL strobe_totals got v=%0d f=%0d both=%0d want v=%0d f=%0d both=0",
               nvalid, nferr, nboth, exp_nvalid, exp_nferr);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single_errors();
    test_framing();
    test_random_en();
    test_back_to_back();
    test_midframe_reset();
    test_saturation();
    test_strobe_totals();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
